// File: rtl/lsu_rmw.sv
// Load/store unit that turns byte/half/word stores into read-modify-write on a 32-bit word RAM.
// Latency: load response 2 cycles after accept, store write 2 and response 3 cycles after accept.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held until rsp_ready_i. Option: LSU_MISALIGN_CHECK_EN.
module lsu_rmw #(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [31:0] rd_word;
    logic        req_fire;
    logic        req_bad;
    logic [31:0] load_ext;
    logic [31:0] merged;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        req_bad = ({2'b00, req_addr_i[31:2]} >= 32'(MEM_WORDS)) || (req_size_i == 2'd3);
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size_i == 2'd1 && req_addr_i[0])
            req_bad = 1'b1;
        if (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00)
            req_bad = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_nxt = req_bad ? RESP : READ;
            end
            READ:    state_nxt = lat_we ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_fire = req_valid_i & req_ready_o;

    // Write strobe is gated by reset so an interrupted store never reaches the RAM.
    assign ram_we_o    = (state == WRITE) && rstn;
    assign ram_addr_o  = {lat_addr[31:2], 2'b00};
    assign ram_wdata_o = merged;

    always_comb begin
        byte_sel = ram_rdata_i[{lat_addr[1:0], 3'b000} +: 8];
        half_sel = ram_rdata_i[{lat_addr[1], 4'b0000} +: 16];
        case (lat_size)
            2'd0:    load_ext = {{24{~lat_uns & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~lat_uns & half_sel[15]}}, half_sel};
            default: load_ext = ram_rdata_i;
        endcase
    end

    always_comb begin
        merged = rd_word;
        case (lat_size)
            2'd0:    merged[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
            2'd1:    merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: merged = lat_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_size    <= '0;
            lat_uns     <= 1'b0;
            rd_word     <= '0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            if (req_fire) begin
                lat_we      <= req_we_i;
                lat_addr    <= req_addr_i;
                lat_wdata   <= req_wdata_i;
                lat_size    <= req_size_i;
                lat_uns     <= req_unsigned_i;
                rsp_err_o   <= req_bad;
                rsp_rdata_o <= '0;
            end
            if (state == READ) begin
                rd_word     <= ram_rdata_i;
                rsp_rdata_o <= lat_we ? 32'h0 : load_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word RAM.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o, ram_wdata_o, ram_rdata_i;

    logic [31:0] mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_idx = '0;
    logic [31:0] bd_dat = '0;
    int          wr_count = 0;

    int checks = 0;
    int errors = 0;

    logic [31:0] r_dat, r_wd;
    logic        r_err;
    int          r_lat, r_wn, r_wc;

    lsu_rmw #(.MEM_WORDS(4096)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    assign ram_rdata_i = mem[ram_addr_o[13:2]];

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_dat;
        else if (ram_we_o) begin
            mem[ram_addr_o[13:2]] <= ram_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    task automatic poke(input logic [31:0] byte_addr, input logic [31:0] dat);
        bd_we = 1'b1; bd_idx = byte_addr[13:2]; bd_dat = dat;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issue one request and follow it to its response; returns in RESP when rsp_ready_i is low.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns);
        r_dat = '0; r_err = 1'b0; r_lat = -1; r_wn = -1; r_wc = 0; r_wd = '0;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
        req_size_i = size; req_unsigned_i = uns;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (ram_we_o) begin r_wc++; r_wn = n; r_wd = ram_wdata_o; end
            if (rsp_valid_o) begin r_lat = n; r_dat = rsp_rdata_o; r_err = rsp_err_o; break; end
            @(posedge clk); #1;
        end
        if (r_lat >= 0 && rsp_ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        req_size_i = '0; req_unsigned_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err_o); end
        checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata_o); end
        checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we_o); end
        checks++; if (ram_addr_o !== 32'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready_o); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte();
        poke(32'h10, 32'h11223344);
        poke(32'h24, 32'h000000AA);
        run_req(1'b0, 32'h12, 32'h0, 2'd0, 1'b0);
        checks++; if (r_dat !== 32'h00000022) begin errors++; $display("FAIL ldb_data got %h want 00000022", r_dat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ldb_err got %b want 0", r_err); end
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL ldb_latency got %0d want 1", r_lat); end
        checks++; if (r_wc !== 0) begin errors++; $display("FAIL ldb_no_write got %0d want 0", r_wc); end
        run_req(1'b0, 32'h24, 32'h0, 2'd0, 1'b0);
        checks++; if (r_dat !== 32'hFFFFFFAA) begin errors++; $display("FAIL ldb_signed got %h want FFFFFFAA", r_dat); end
        run_req(1'b0, 32'h24, 32'h0, 2'd0, 1'b1);
        checks++; if (r_dat !== 32'h000000AA) begin errors++; $display("FAIL ldb_unsigned got %h want 000000AA", r_dat); end
        run_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0);
        checks++; if (r_dat !== 32'h00000011) begin errors++; $display("FAIL ldb_lane3 got %h want 00000011", r_dat); end
    endtask

    task automatic test_load_half();
        poke(32'h20, 32'h8000F0AA);
        run_req(1'b0, 32'h22, 32'h0, 2'd1, 1'b0);
        checks++; if (r_dat !== 32'hFFFF8000) begin errors++; $display("FAIL ldh_signed got %h want FFFF8000", r_dat); end
        run_req(1'b0, 32'h22, 32'h0, 2'd1, 1'b1);
        checks++; if (r_dat !== 32'h00008000) begin errors++; $display("FAIL ldh_unsigned got %h want 00008000", r_dat); end
        run_req(1'b0, 32'h20, 32'h0, 2'd1, 1'b0);
        checks++; if (r_dat !== 32'hFFFFF0AA) begin errors++; $display("FAIL ldh_low got %h want FFFFF0AA", r_dat); end
    endtask

    task automatic test_store_rmw();
        poke(32'h30, 32'hAABBCCDD);
        run_req(1'b1, 32'h31, 32'h0000005E, 2'd0, 1'b0);
        checks++; if (r_wc !== 1) begin errors++; $display("FAIL stb_we_count got %0d want 1", r_wc); end
        checks++; if (r_wn !== 1) begin errors++; $display("FAIL stb_we_cycle got %0d want 1", r_wn); end
        checks++; if (r_wd !== 32'hAABB5EDD) begin errors++; $display("FAIL stb_wdata got %h want AABB5EDD", r_wd); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL stb_latency got %0d want 2", r_lat); end
        checks++; if (r_dat !== 32'h0 || r_err !== 1'b0) begin errors++; $display("FAIL stb_rsp got %h/%b want 0/0", r_dat, r_err); end
        run_req(1'b0, 32'h30, 32'h0, 2'd2, 1'b0);
        checks++; if (r_dat !== 32'hAABB5EDD) begin errors++; $display("FAIL stb_readback got %h want AABB5EDD", r_dat); end
        run_req(1'b1, 32'h32, 32'h1234BEEF, 2'd1, 1'b0);
        checks++; if (r_wd !== 32'hBEEF5EDD) begin errors++; $display("FAIL sth_wdata got %h want BEEF5EDD", r_wd); end
        run_req(1'b1, 32'h34, 32'h12345678, 2'd2, 1'b0);
        run_req(1'b0, 32'h34, 32'h0, 2'd2, 1'b0);
        checks++; if (r_dat !== 32'h12345678) begin errors++; $display("FAIL stw_readback got %h want 12345678", r_dat); end
    endtask

    task automatic test_errors();
        int wc0;
        wc0 = wr_count;
        run_req(1'b1, 32'h4000, 32'hFFFFFFFF, 2'd2, 1'b0);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL oor_err got %b want 1", r_err); end
        checks++; if (r_lat !== 0) begin errors++; $display("FAIL oor_latency got %0d want 0", r_lat); end
        checks++; if (r_wc !== 0 || wr_count !== wc0) begin errors++; $display("FAIL oor_no_write got %0d want 0", wr_count - wc0); end
        run_req(1'b0, 32'h10, 32'h0, 2'd3, 1'b0);
        checks++; if (r_err !== 1'b1 || r_dat !== 32'h0) begin errors++; $display("FAIL size3 got %b/%h want 1/0", r_err, r_dat); end
        run_req(1'b1, 32'h3FFC, 32'hDEADBEEF, 2'd2, 1'b0);
        checks++; if (r_err !== 1'b0 || r_wc !== 1) begin errors++; $display("FAIL last_word_store got %b/%0d want 0/1", r_err, r_wc); end
        run_req(1'b0, 32'h3FFC, 32'h0, 2'd2, 1'b0);
        checks++; if (r_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL last_word_load got %h want DEADBEEF", r_dat); end
        run_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        checks++; if (r_err !== 1'b0 || r_dat !== 32'h11223344) begin errors++; $display("FAIL err_cleared got %b/%h want 0/11223344", r_err, r_dat); end
    endtask

    task automatic test_misalign();
        poke(32'h40, 32'hCAFEF00D);
        run_req(1'b0, 32'h41, 32'h0, 2'd2, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++; if (r_err !== 1'b1 || r_dat !== 32'h0) begin errors++; $display("FAIL mis_word got %b/%h want 1/0", r_err, r_dat); end
        run_req(1'b0, 32'h43, 32'h0, 2'd1, 1'b0);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL mis_half got %b want 1", r_err); end
`else
        checks++; if (r_err !== 1'b0 || r_dat !== 32'hCAFEF00D) begin errors++; $display("FAIL mis_word got %b/%h want 0/CAFEF00D", r_err, r_dat); end
        run_req(1'b0, 32'h43, 32'h0, 2'd1, 1'b0);
        checks++; if (r_err !== 1'b0 || r_dat !== 32'hFFFFCAFE) begin errors++; $display("FAIL mis_half got %b/%h want 0/FFFFCAFE", r_err, r_dat); end
`endif
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        run_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        checks++; if (r_lat !== 1 || r_dat !== 32'h8000F0AA) begin errors++; $display("FAIL bp_first got %0d/%h want 1/8000F0AA", r_lat, r_dat); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h8000F0AA || req_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want v=1 d=8000F0AA rdy=0", i, rsp_valid_o, rsp_rdata_o, req_ready_o);
            end
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", rsp_valid_o, req_ready_o); end
    endtask

    task automatic test_reset_mid_write();
        int wc0;
        poke(32'h50, 32'h01020304);
        wc0 = wr_count;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h50; req_wdata_i = 32'hFF;
        req_size_i = 2'd0; req_unsigned_i = 1'b0;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (ram_we_o !== 1'b1) begin errors++; $display("FAIL rst_write_reached got %b want 1", ram_we_o); end
        rstn = 1'b0;
        #1;
        checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_we_gated got %b want 0", ram_we_o); end
        @(posedge clk); #1;
        rstn = 1'b1;
        checks++; if (wr_count !== wc0 || mem[20] !== 32'h01020304) begin errors++; $display("FAIL rst_no_write got %h want 01020304", mem[20]); end
        checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle got v=%b rdy=%b want 0/1", rsp_valid_o, req_ready_o); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid_o !== 1'b0 || ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_no_rsp%0d got v=%b we=%b want 0/0", i, rsp_valid_o, ram_we_o); end
        end
        run_req(1'b0, 32'h50, 32'h0, 2'd2, 1'b0);
        checks++; if (r_dat !== 32'h01020304 || r_err !== 1'b0) begin errors++; $display("FAIL rst_recover got %h/%b want 01020304/0", r_dat, r_err); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_store_rmw();
        test_errors();
        test_misalign();
        test_backpressure();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
